// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: stall, flush and flush_pc are combinational from inputs and state; watchdog and counters registered.
// Define PIPELINE_PERF_COUNTER_EN to build the load-use and memory stall performance counters.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
    parameter int          FLUSH_CYCLES  = 1,
    parameter int          TIMEOUT_WIDTH = 16,
    parameter int          PERF_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_related_1,
    input  logic                  load_related_2,
    input  logic                  stall_req_if,
    input  logic                  stall_req_mem,
    input  logic                  exc_flag,
    output logic [4:0]            stall,
    output logic                  flush,
    output logic [31:0]           flush_pc,
    output logic                  stall_timeout,
    output logic [PERF_WIDTH-1:0] load_stall_cnt,
    output logic [PERF_WIDTH-1:0] mem_stall_cnt
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX = '1;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CW-1:0]            r_cnt;
    logic [CW-1:0]            w_cnt_nxt;
    logic [TIMEOUT_WIDTH-1:0] r_wd;
    logic [TIMEOUT_WIDTH-1:0] w_wd_nxt;
    logic                     r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall       = 5'b00000;
        flush       = 1'b0;
        case (r_state)
            S_RUN: begin
                // A memory stall freezes MEM, so a pending exception waits there until it releases.
                if (stall_req_mem) begin
                    stall = 5'b11111;
                end else if (exc_flag) begin
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = S_FLUSH;
                        w_cnt_nxt   = CW'(FLUSH_CYCLES - 1);
                    end
                end else if (load_related_1 || load_related_2) begin
                    stall = 5'b00011;
                end else if (stall_req_if) begin
                    stall = 5'b00001;
                end
            end
            S_FLUSH: begin
                flush     = 1'b1;
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign flush_pc = flush ? EXC_VECTOR : 32'h0;

    always_comb begin
        w_wd_nxt = r_wd;
        if (flush || (stall == 5'b00000)) begin
            w_wd_nxt = '0;
        end else if (r_wd != WD_MAX) begin
            w_wd_nxt = r_wd + TIMEOUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wd <= w_wd_nxt;
            if (w_wd_nxt == WD_MAX) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign stall_timeout = r_timeout;

`ifdef PIPELINE_PERF_COUNTER_EN
    logic                  w_load_use;
    logic                  w_mem_win;
    logic [PERF_WIDTH-1:0] r_load_cnt;
    logic [PERF_WIDTH-1:0] r_mem_cnt;

    assign w_load_use = (stall == 5'b00011);
    assign w_mem_win  = (r_state == S_RUN) && stall_req_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_cnt <= '0;
            r_mem_cnt  <= '0;
        end else begin
            if (w_load_use) begin
                r_load_cnt <= r_load_cnt + PERF_WIDTH'(1);
            end
            if (w_mem_win) begin
                r_mem_cnt <= r_mem_cnt + PERF_WIDTH'(1);
            end
        end
    end

    assign load_stall_cnt = r_load_cnt;
    assign mem_stall_cnt  = r_mem_cnt;
`else
    assign load_stall_cnt = '0;
    assign mem_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int FC     = 3;
    localparam int TW     = 4;
    localparam int WD_MAX = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_related_1 = 1'b0;
    logic        load_related_2 = 1'b0;
    logic        stall_req_if = 1'b0;
    logic        stall_req_mem = 1'b0;
    logic        exc_flag = 1'b0;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        stall_timeout;
    logic [31:0] load_stall_cnt;
    logic [31:0] mem_stall_cnt;

    pipeline_ctrl #(
        .EXC_VECTOR   (32'hBFC00380),
        .FLUSH_CYCLES (FC),
        .TIMEOUT_WIDTH(TW),
        .PERF_WIDTH   (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_related_1(load_related_1),
        .load_related_2(load_related_2),
        .stall_req_if  (stall_req_if),
        .stall_req_mem (stall_req_mem),
        .exc_flag      (exc_flag),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .stall_timeout (stall_timeout),
        .load_stall_cnt(load_stall_cnt),
        .mem_stall_cnt (mem_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: flush cycles still owed after an accepted exception, consecutive stall cycles.
    int          m_flush_left = 0;
    int          m_stall_run  = 0;
    bit          m_timeout    = 1'b0;
    logic [31:0] m_load_cnt   = '0;
    logic [31:0] m_mem_cnt    = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_stall_run  = 0;
        m_timeout    = 1'b0;
        m_load_cnt   = '0;
        m_mem_cnt    = '0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input bit r, input bit l1, input bit l2, input bit fi,
                        input bit fm, input bit ex, input string tag);
        logic [4:0] e_stall;
        bit         e_flush;
        bit         load_use;
        bit         mem_win;
        @(negedge clk);
        rst            = r;
        load_related_1 = l1;
        load_related_2 = l2;
        stall_req_if   = fi;
        stall_req_mem  = fm;
        exc_flag       = ex;
        #1;
        e_stall  = 5'b00000;
        e_flush  = 1'b0;
        load_use = 1'b0;
        mem_win  = 1'b0;
        if (m_flush_left > 0) e_flush = 1'b1;
        else if (fm) begin e_stall = 5'b11111; mem_win = 1'b1; end
        else if (ex) e_flush = 1'b1;
        else if (l1 || l2) begin e_stall = 5'b00011; load_use = 1'b1; end
        else if (fi) e_stall = 5'b00001;
        if (!r) begin
            chk({tag, ".stall"}, 64'(stall), 64'(e_stall));
            chk({tag, ".flush"}, 64'(flush), 64'(e_flush));
            chk({tag, ".flush_pc"}, 64'(flush_pc), e_flush ? 64'hBFC00380 : 64'h0);
            chk({tag, ".timeout"}, 64'(stall_timeout), 64'(m_timeout));
`ifdef PIPELINE_PERF_COUNTER_EN
            chk({tag, ".load_cnt"}, 64'(load_stall_cnt), 64'(m_load_cnt));
            chk({tag, ".mem_cnt"}, 64'(mem_stall_cnt), 64'(m_mem_cnt));
`else
            chk({tag, ".load_cnt"}, 64'(load_stall_cnt), 64'h0);
            chk({tag, ".mem_cnt"}, 64'(mem_stall_cnt), 64'h0);
`endif
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (m_flush_left > 0) m_flush_left--;
            else if (!fm && ex) m_flush_left = FC - 1;
            if (e_stall != 5'b00000 && !e_flush) begin
                if (m_stall_run < WD_MAX) m_stall_run++;
            end else begin
                m_stall_run = 0;
            end
            if (m_stall_run == WD_MAX) m_timeout = 1'b1;
            if (load_use) m_load_cnt = m_load_cnt + 32'd1;
            if (mem_win) m_mem_cnt = m_mem_cnt + 32'd1;
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, "rst");
        step(1, 0, 0, 0, 0, 0, "rst");
    endtask

    initial begin
        do_reset();
        step(0, 0, 0, 0, 0, 0, "reset_state");

        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, "load_use");
        step(0, 0, 0, 0, 0, 0, "after_load_use");

        step(0, 0, 0, 0, 1, 1, "mem_exc");
        step(0, 0, 0, 0, 1, 1, "mem_exc");
        step(0, 0, 0, 0, 0, 1, "exc_taken");
        step(0, 0, 0, 0, 0, 0, "flush_tail");
        step(0, 0, 0, 0, 0, 0, "flush_tail");
        step(0, 0, 0, 0, 0, 0, "post_flush");

        step(0, 0, 0, 0, 0, 1, "exc_pulse");
        step(0, 0, 1, 0, 0, 0, "flush_lr2");
        step(0, 0, 1, 1, 1, 1, "flush_ignore");
        step(0, 0, 1, 0, 0, 0, "after_flush_lr2");

        do_reset();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 0, "watchdog");
        step(0, 0, 0, 0, 0, 0, "watchdog_release");
        step(0, 1, 1, 1, 0, 0, "lr_and_if");

        do_reset();
        step(0, 0, 0, 0, 0, 1, "exc_before_rst");
        step(1, 0, 0, 0, 0, 0, "rst_mid_flush");
        step(0, 0, 0, 0, 0, 0, "after_rst_mid_flush");

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
